intr_ack_seq: RTL
=================

INTR_ACK_SEQ -- requirements
Module: intr_ack_seq

Interface
REQ-001 Parameter PULSE_W, default 2: cycles inta_n/wr_n held low per strobe (legal 1..15).
REQ-002 Parameter GAP_W, default 2: cycles inta_n held high between the two INTA strobes (legal 1..15).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 intr  in  1  INT output of the 8259; asynchronous to clk.
REQ-006 if_en  in  1  CPU interrupt-enable flag; gates new acknowledge cycles.
REQ-007 inta_n  out  1  interrupt-acknowledge strobe to the 8259, active-low.
REQ-008 pic_cs_n, pic_wr_n, pic_rd_n  out  1 each  8259 chip select, write and read strobes, active-low.
REQ-009 pic_a0  out  1  8259 address line.
REQ-010 pic_dout  out  8  data driven to the 8259; pic_doe  out  1  bus drive enable.
REQ-011 pic_din  in  8  data bus from the 8259.
REQ-012 vec  out  8  captured interrupt vector; vec_valid  out  1; vec_ready  in  1.
REQ-013 eoi_req  in  1  one-cycle EOI request; eoi_busy  out  1  EOI write in progress.
REQ-014 vec_drop  out  1  sticky flag, vector discarded on timeout (see Configuration).

Function
REQ-015 intr passes through a 2-flop synchronizer (intr_s); no other input is synchronized.
REQ-016 States: IDLE, ACK1, GAP, ACK2, PRESENT, EOI_WR, EOI_REC.
REQ-017 IDLE: eoi_req=1 -> EOI_WR (priority); else intr_s=1 & if_en=1 -> ACK1; else stay.
REQ-018 ACK1: inta_n=0 for PULSE_W cycles -> GAP.
REQ-019 GAP: inta_n=1 for GAP_W cycles -> ACK2.
REQ-020 ACK2: inta_n=0 for PULSE_W cycles; vec <= pic_din on the last ACK2 cycle -> PRESENT.
REQ-021 PRESENT: vec_valid=1, vec stable; vec_valid & vec_ready -> IDLE, vec_valid=0 next cycle.
REQ-022 Registered outputs: inta_n falls on the edge entering ACK1, i.e. the 3rd rising edge after intr rises.
REQ-023 EOI_WR: pic_cs_n=0, pic_wr_n=0, pic_a0=0, pic_dout=8'h20, pic_doe=1 for PULSE_W cycles -> EOI_REC.
REQ-024 EOI_REC: one cycle, all strobes high, pic_doe=0, pic_dout=8'h20 held -> IDLE.
REQ-025 eoi_busy=1 in EOI_WR and EOI_REC only.
REQ-026 eoi_req outside IDLE ignored (not queued); caller retries while eoi_busy=0 and vec_valid=0.
REQ-027 intr_s falling during ACK1/GAP/ACK2 does not abort; sequence completes and vector is presented.
REQ-028 pic_rd_n held 1 at all times; pic_cs_n=1 except in EOI_WR.
REQ-029 if_en low after leaving IDLE does not abort the sequence.
REQ-030 Pulse/gap counters are 4-bit, cleared on every state entry; no wrap beyond 15.

Reset
REQ-031 rst_n=0 forces immediately: state IDLE, inta_n=1, pic_cs_n=1, pic_wr_n=1, pic_rd_n=1, pic_a0=0, pic_dout=0, pic_doe=0, vec=0, vec_valid=0, eoi_busy=0, vec_drop=0, synchronizer=0.
REQ-032 Reset mid-sequence (any state) aborts without completing strobes; first post-reset cycle sees inta_n=1.

Configuration
REQ-033 Macro INTR_ACK_TIMEOUT_EN defined: 8-bit counter in PRESENT; 255 cycles without vec_ready -> vec_valid=0, vec_drop=1 (sticky until reset), state IDLE.
REQ-034 Macro undefined: no counter, PRESENT waits indefinitely, vec_drop tied 0.

Verification
REQ-035 intr=1 (IR7, ICW base 8'h08), if_en=1, pic_din=8'h0F during ACK2 -> exactly two inta_n pulses of PULSE_W cycles separated by GAP_W, vec=8'h0F, vec_valid until vec_ready.
REQ-036 eoi_req pulse in IDLE -> pic_cs_n=pic_wr_n=0, pic_a0=0, pic_dout=8'h20, pic_doe=1 for PULSE_W cycles, then one recovery cycle, eoi_busy high 3 cycles total (PULSE_W=2).
REQ-037 intr=1 and eoi_req=1 together in IDLE -> EOI write first, then ACK1 begins on the edge after EOI_REC.
REQ-038 intr=1 with if_en=0 for 20 cycles -> inta_n stays 1; raise if_en -> ACK1 entered next edge.
REQ-039 rst_n low during GAP -> all outputs at reset values immediately; after release with intr=1 a fresh two-pulse sequence occurs.
REQ-040 INTR_ACK_TIMEOUT_EN defined, vec_ready held 0 -> vec_valid drops after 255 PRESENT cycles, vec_drop=1; undefined -> vec_valid held for 1000 cycles, vec_drop=0.

Source files
------------

// File: rtl/intr_ack_seq_if.sv
// intr_ack_seq_if -- signal bundle between the 8259 acknowledge sequencer and
// its surroundings (CPU side and 8259 side share one bundle).
//
// Ports (as seen by the sequencer, modport slave):
//   in : intr, if_en, pic_din[7:0], vec_ready, eoi_req
//   out: inta_n, pic_cs_n, pic_wr_n, pic_rd_n, pic_a0, pic_dout[7:0], pic_doe,
//        vec[7:0], vec_valid, eoi_busy, vec_drop
// The master modport is the mirror image, used by whatever drives the
// sequencer's inputs.
//
// Vector handshake: vec is transferred on every rising clk edge where
// vec_valid and vec_ready are both 1. Once vec_valid rises it stays high and
// vec stays constant until that transfer edge; vec_ready may be driven
// independently of vec_valid and is ignored while vec_valid is 0.
interface intr_ack_seq_if;
    logic       intr;
    logic       if_en;
    logic       inta_n;
    logic       pic_cs_n;
    logic       pic_wr_n;
    logic       pic_rd_n;
    logic       pic_a0;
    logic [7:0] pic_dout;
    logic       pic_doe;
    logic [7:0] pic_din;
    logic [7:0] vec;
    logic       vec_valid;
    logic       vec_ready;
    logic       eoi_req;
    logic       eoi_busy;
    logic       vec_drop;

    modport slave (
        input  intr, if_en, pic_din, vec_ready, eoi_req,
        output inta_n, pic_cs_n, pic_wr_n, pic_rd_n, pic_a0, pic_dout, pic_doe,
               vec, vec_valid, eoi_busy, vec_drop
    );

    modport master (
        output intr, if_en, pic_din, vec_ready, eoi_req,
        input  inta_n, pic_cs_n, pic_wr_n, pic_rd_n, pic_a0, pic_dout, pic_doe,
               vec, vec_valid, eoi_busy, vec_drop
    );
endinterface

// File: rtl/intr_ack_seq.sv
// intr_ack_seq -- 8259 interrupt acknowledge / EOI sequencer.
//
// Generates the two INTA strobes of an 8259 acknowledge cycle, captures the
// vector on the second strobe and presents it on a valid/ready port. Also
// issues a non-specific EOI write (8'h20 at A0=0) on request.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   bus        slave modport of intr_ack_seq_if (see that file)
//   state_dbg  out  current FSM state encoding (debug observation)
//
// Parameters:
//   PULSE_W  low time of each inta_n / wr_n strobe in cycles (1..15)
//   GAP_W    inta_n high time between the two INTA strobes (1..15)
//
// Optional feature: define INTR_ACK_TIMEOUT_EN to drop a presented vector
// after 255 cycles without vec_ready (sets sticky vec_drop). Without it the
// vector is held indefinitely and vec_drop is tied low.
module intr_ack_seq #(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    intr_ack_seq_if.slave      bus,
    output logic [2:0]         state_dbg
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ACK1    = 3'd1;
    localparam logic [2:0] S_GAP     = 3'd2;
    localparam logic [2:0] S_ACK2    = 3'd3;
    localparam logic [2:0] S_PRESENT = 3'd4;
    localparam logic [2:0] S_EOI_WR  = 3'd5;
    localparam logic [2:0] S_EOI_REC = 3'd6;

    localparam logic [3:0] PULSE_LAST = 4'(PULSE_W - 1);
    localparam logic [3:0] GAP_LAST   = 4'(GAP_W - 1);
    localparam logic [7:0] EOI_CMD    = 8'h20;

    logic       sync1_q;
    logic       intr_s_q;
    logic [2:0] state_q,     state_d;
    logic [3:0] cnt_q,       cnt_d;
    logic       inta_n_q,    inta_n_d;
    logic       wr_strobe_n_q, wr_strobe_n_d;  // drives both pic_cs_n and pic_wr_n
    logic [7:0] dout_q,      dout_d;
    logic       doe_q,       doe_d;
    logic [7:0] vec_q,       vec_d;
    logic       vec_valid_q, vec_valid_d;
    logic       eoi_busy_q,  eoi_busy_d;
`ifdef INTR_ACK_TIMEOUT_EN
    logic [7:0] tmo_q,       tmo_d;
    logic       vec_drop_q,  vec_drop_d;
`endif

    // Next-state logic and all registered outputs derived from the next state,
    // so every strobe changes exactly on the edge that enters its state.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
`ifdef INTR_ACK_TIMEOUT_EN
        vec_drop_d = vec_drop_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.eoi_req)                 state_d = S_EOI_WR;
                else if (intr_s_q && bus.if_en)  state_d = S_ACK1;
            end
            S_ACK1:    if (cnt_q == PULSE_LAST) state_d = S_GAP;
            S_GAP:     if (cnt_q == GAP_LAST)   state_d = S_ACK2;
            S_ACK2: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = S_PRESENT;
                    vec_d   = bus.pic_din;
                end
            end
            S_PRESENT: begin
                if (bus.vec_ready) begin
                    state_d = S_IDLE;
                end
`ifdef INTR_ACK_TIMEOUT_EN
                // tmo_q counts completed PRESENT cycles; 254 means this is the 255th.
                else if (tmo_q == 8'd254) begin
                    state_d    = S_IDLE;
                    vec_drop_d = 1'b1;
                end
`endif
            end
            S_EOI_WR:  if (cnt_q == PULSE_LAST) state_d = S_EOI_REC;
            S_EOI_REC: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        // Counter restarts on every state entry and saturates instead of wrapping.
        if (state_d != state_q)  cnt_d = 4'd0;
        else if (cnt_q == 4'hF)  cnt_d = cnt_q;
        else                     cnt_d = cnt_q + 4'd1;

`ifdef INTR_ACK_TIMEOUT_EN
        if (state_q == S_PRESENT && state_d == S_PRESENT) tmo_d = tmo_q + 8'd1;
        else                                              tmo_d = 8'd0;
`endif

        inta_n_d      = !((state_d == S_ACK1) || (state_d == S_ACK2));
        wr_strobe_n_d = (state_d != S_EOI_WR);
        doe_d         = (state_d == S_EOI_WR);
        eoi_busy_d    = (state_d == S_EOI_WR) || (state_d == S_EOI_REC);
        dout_d        = eoi_busy_d ? EOI_CMD : 8'h00;
        vec_valid_d   = (state_d == S_PRESENT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= 1'b0;
            intr_s_q      <= 1'b0;
            state_q       <= S_IDLE;
            cnt_q         <= 4'd0;
            inta_n_q      <= 1'b1;
            wr_strobe_n_q <= 1'b1;
            dout_q        <= 8'h00;
            doe_q         <= 1'b0;
            vec_q         <= 8'h00;
            vec_valid_q   <= 1'b0;
            eoi_busy_q    <= 1'b0;
        end else begin
            sync1_q       <= bus.intr;
            intr_s_q      <= sync1_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            inta_n_q      <= inta_n_d;
            wr_strobe_n_q <= wr_strobe_n_d;
            dout_q        <= dout_d;
            doe_q         <= doe_d;
            vec_q         <= vec_d;
            vec_valid_q   <= vec_valid_d;
            eoi_busy_q    <= eoi_busy_d;
        end
    end

`ifdef INTR_ACK_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q      <= 8'd0;
            vec_drop_q <= 1'b0;
        end else begin
            tmo_q      <= tmo_d;
            vec_drop_q <= vec_drop_d;
        end
    end
    assign bus.vec_drop = vec_drop_q;
`else
    assign bus.vec_drop = 1'b0;
`endif

    assign bus.inta_n    = inta_n_q;
    assign bus.pic_cs_n  = wr_strobe_n_q;
    assign bus.pic_wr_n  = wr_strobe_n_q;
    assign bus.pic_rd_n  = 1'b1;   // the sequencer never reads the 8259 registers
    assign bus.pic_a0    = 1'b0;   // OCW2 (EOI) lives at A0=0
    assign bus.pic_dout  = dout_q;
    assign bus.pic_doe   = doe_q;
    assign bus.vec       = vec_q;
    assign bus.vec_valid = vec_valid_q;
    assign bus.eoi_busy  = eoi_busy_q;
    assign state_dbg     = state_q;

endmodule
